// File: rtl/score_recorder_pkg.sv
// Shared constants, seven-segment codes and helpers for the score recorder.
package score_recorder_pkg;

  localparam int ROUNDS_DEF    = 4;
  localparam int MISS_TIME_DEF = 999;
  localparam int BIN_W         = 10;
  localparam int BCD_W         = 12;
  localparam int SR_W          = BCD_W + BIN_W;

  // Active-low seven-segment codes (bit 6 = segment g ... bit 0 = segment a).
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_SHIFT = 2'd1,
    CV_DONE  = 2'd2
  } conv_state_t;

  // Observation bundle for the converter FSM.
  typedef struct packed {
    conv_state_t state;
    logic        busy;
  } dbg_t;

  // Decimal digit to active-low segments; anything above 9 shows blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int i = 0; i < 3; i++) begin
      if (t[BIN_W + 4*i +: 4] >= 4'd5)
        t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/score_recorder_if.sv
// Result channel from the game controller to the score recorder.
// Handshake: strobe-only, no back-pressure. win is meaningful only in a
// cycle where enable=1; each such cycle carries exactly one round result.
// nothing is a level that stays high while the controller is idle.
interface score_recorder_if;
  import score_recorder_pkg::*;

  logic [BIN_W-1:0] win;
  logic             enable;
  logic             nothing;

  modport master (output win, output enable, output nothing);
  modport slave  (input  win, input  enable, input  nothing);
endinterface

// File: rtl/score_recorder_bin2bcd.sv
// Iterative 10-bit binary to 3-digit BCD converter (double dabble).
// A start pulse loads the operand; ten shift cycles follow; the result is
// presented with a one-cycle valid. A start in any state restarts.
module bin2bcd_seq
  import score_recorder_pkg::*;
(
  input  logic             clk,
  input  logic             KEY1,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             valid,
  output logic [BCD_W-1:0] bcd,
  output conv_state_t      state
);

  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_next;
  logic [3:0]      cnt;

  assign sr_next = dabble_step(sr);

  // Converter FSM: IDLE -> SHIFT (10 edges) -> DONE (valid) -> IDLE.
  always_ff @(posedge clk) begin
    if (!KEY1) begin
      state <= CV_IDLE;
      sr    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      bcd   <= '0;
    end else if (start) begin
      state <= CV_SHIFT;
      sr    <= {{BCD_W{1'b0}}, bin};
      cnt   <= '0;
      busy  <= 1'b1;
      valid <= 1'b0;
    end else begin
      case (state)
        CV_SHIFT: begin
          if (cnt == 4'd9) begin
            // Tenth shift: publish the digits straight from the step result.
            bcd   <= sr_next[SR_W-1:BIN_W];
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= CV_DONE;
          end else begin
            sr  <= sr_next;
            cnt <= cnt + 4'd1;
          end
        end
        CV_DONE: begin
          valid <= 1'b0;
          state <= CV_IDLE;
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= CV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/score_recorder.sv
// Records the round results of one game, keeps best time and running sum,
// and shows last/best/average on HEX2..HEX0 with the round count on HEX3.
module score_recorder
  import score_recorder_pkg::*;
#(
  parameter int ROUNDS    = ROUNDS_DEF,
  parameter int MISS_TIME = MISS_TIME_DEF
) (
  input  logic             clk,
  input  logic [1:0]       KEY,
  score_recorder_if.slave  res,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic             done,
  output dbg_t             dbg
);

  localparam int RND_W = $clog2(ROUNDS + 1);
  localparam int IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  logic [BIN_W-1:0] slot [ROUNDS];
  logic [11:0]      sum;
  logic [BIN_W-1:0] best;
  logic [RND_W-1:0] rnd;
  logic             pending;
  logic [BIN_W-1:0] last_dv;
  logic             key0_q;
  logic [6:0]       hex0_q, hex1_q, hex2_q;

  logic [BIN_W-1:0] w;
  logic [BIN_W-1:0] avg;
  logic [BIN_W-1:0] dv;
  logic             blank;
  logic             accept;
  logic             start;
  logic [IDX_W-1:0] last_idx;

  logic             cv_busy;
  logic             cv_valid;
  logic [BCD_W-1:0] cv_bcd;
  conv_state_t      cv_state;
  logic [3:0]       d_hun, d_ten, d_one;

  // Misses and anything out of range are recorded as the miss time.
  assign w        = (res.win > BIN_W'(MISS_TIME)) ? BIN_W'(MISS_TIME) : res.win;
  assign accept   = res.enable && (rnd < RND_W'(ROUNDS));
  assign avg      = sum[11:2];
  assign last_idx = IDX_W'(rnd - RND_W'(1));

  // Display value selection; blank while idle before the first result.
  always_comb begin
    dv    = '0;
    blank = 1'b0;
    if (rnd == '0 && res.nothing)
      blank = 1'b1;
    else if (!key0_q && done)
      dv = avg;
    else if (done)
      dv = best;
    else if (rnd != '0)
      dv = slot[last_idx];
  end

  // A new conversion whenever the shown value moves or one is owed after reset.
  assign start = !blank && ((dv != last_dv) || pending);

  // View-select button is registered so its effect is edge-aligned.
  always_ff @(posedge clk) begin
    key0_q <= KEY[0];
  end

  // Result capture, conversion bookkeeping and digit latching.
  always_ff @(posedge clk) begin
    if (!KEY[1]) begin
      for (int i = 0; i < ROUNDS; i++) slot[i] <= '0;
      sum     <= '0;
      best    <= BIN_W'(MISS_TIME);
      rnd     <= '0;
      done    <= 1'b0;
      pending <= 1'b1;
      last_dv <= '0;
      hex0_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
    end else begin
      if (accept) begin
        slot[IDX_W'(rnd)] <= w;
        sum               <= sum + 12'(w);
        if (w < best) best <= w;
        rnd <= rnd + RND_W'(1);
        if (rnd == RND_W'(ROUNDS - 1)) done <= 1'b1;
      end
      if (start) begin
        last_dv <= dv;
        pending <= 1'b0;
      end
      if (blank) begin
        hex0_q <= SEG_BLANK;
        hex1_q <= SEG_BLANK;
        hex2_q <= SEG_BLANK;
      end else if (cv_valid && !start) begin
        // A result that coincides with a restart belongs to a stale value.
        hex0_q <= seg7(d_one);
        hex1_q <= (d_hun == 4'd0 && d_ten == 4'd0) ? SEG_BLANK : seg7(d_ten);
        hex2_q <= (d_hun == 4'd0) ? SEG_BLANK : seg7(d_hun);
      end
    end
  end

  assign d_hun = cv_bcd[11:8];
  assign d_ten = cv_bcd[7:4];
  assign d_one = cv_bcd[3:0];

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .KEY1  (KEY[1]),
    .start (start),
    .bin   (dv),
    .busy  (cv_busy),
    .valid (cv_valid),
    .bcd   (cv_bcd),
    .state (cv_state)
  );

  assign HEX0 = blank ? SEG_BLANK : hex0_q;
  assign HEX1 = blank ? SEG_BLANK : hex1_q;
  assign HEX2 = blank ? SEG_BLANK : hex2_q;
  assign HEX3 = seg7(4'(rnd));

  assign dbg.state = cv_state;
  assign dbg.busy  = cv_busy;

endmodule
